// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in/serial-out shift register with
// word framing. A WIDTH-bit word is loaded and shifted out one bit per enabled
// clock. COUNT tracks the bits still to be sent, and BUSY/DONE frame each word,
// so back-to-back loads run with no gap.
//
// Parameters:
//   WIDTH     - word length in bits (2..64)
//   LSB_FIRST - 0: MSB first, SI enters at bit 0; 1: LSB first, SI enters at bit WIDTH-1
// Ports:
//   CLK   - rising-edge clock
//   RESET - synchronous active-high reset, overrides all other inputs
//   CE    - clock enable; gates LOAD and shifting
//   SI    - serial input, fills the vacated end of the register
//   PI    - parallel word, captured on load
//   LOAD  - load request, honoured only when CE=1
//   O     - serial output (the register's exit bit)
//   BUSY  - a loaded word still has unsent bits
//   DONE  - one-cycle pulse after the final bit of a word is consumed
//   COUNT - bits of the current word not yet shifted out, including the bit on O
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           CE,
    input  logic                           SI,
    input  logic [WIDTH-1:0]               PI,
    input  logic                           LOAD,
    output logic                           O,
    output logic                           BUSY,
    output logic                           DONE,
    output logic [$clog2(WIDTH+1)-1:0]     COUNT
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    count_d;
    logic             done_d;
    logic             busy_d;

    // Next-state: hold / load / shift, in that priority under CE.
    always_comb begin
        shreg_d = shreg_q;
        count_d = COUNT;
        done_d  = 1'b0;
        if (CE) begin
            if (LOAD) begin
                shreg_d = PI;
                count_d = CW'(WIDTH);
                // Loading on the last bit completes the old word (back-to-back).
                done_d  = (COUNT == CW'(1));
            end else begin
                if (LSB_FIRST) begin
                    shreg_d = {SI, shreg_q[WIDTH-1:1]};
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], SI};
                end
                // Idle shifting keeps running with COUNT pinned at zero.
                if (COUNT != '0) begin
                    count_d = COUNT - CW'(1);
                    done_d  = (COUNT == CW'(1));
                end
            end
        end
        // BUSY is kept as its own flop, tracking the next COUNT.
        busy_d = (count_d != '0);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg_q <= '0;
            COUNT   <= '0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            COUNT   <= count_d;
            DONE    <= done_d;
            BUSY    <= busy_d;
        end
    end

    // Exit bit of the register.
    assign O = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) share stimulus; directed scenarios plus a randomized run
// against a bit-queue reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       si;
    logic       load;
    logic [3:0] pi4;
    logic [7:0] pi8;

    logic       o4m, b4m, d4m;
    logic [2:0] c4m;
    logic       o4l, b4l, d4l;
    logic [2:0] c4l;
    logic       o8m, b8m, d8m;
    logic [3:0] c8m;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u4m (
        .CLK(clk), .RESET(rst), .CE(ce), .SI(si), .PI(pi4), .LOAD(load),
        .O(o4m), .BUSY(b4m), .DONE(d4m), .COUNT(c4m));
    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u4l (
        .CLK(clk), .RESET(rst), .CE(ce), .SI(si), .PI(pi4), .LOAD(load),
        .O(o4l), .BUSY(b4l), .DONE(d4l), .COUNT(c4l));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (
        .CLK(clk), .RESET(rst), .CE(ce), .SI(si), .PI(pi8), .LOAD(load),
        .O(o8m), .BUSY(b8m), .DONE(d8m), .COUNT(c8m));

    // Reference model: bits held in shift order, index 0 is the bit on O.
    bit mb[3][64];
    int mc[3];
    bit md[3];
    int mw[3] = '{4, 4, 8};
    bit ml[3] = '{1'b0, 1'b1, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        logic [7:0] p;
        for (int i = 0; i < 3; i++) begin
            p = (i == 2) ? pi8 : {4'b0, pi4};
            if (rst) begin
                for (int k = 0; k < 64; k++) mb[i][k] = 1'b0;
                mc[i] = 0;
                md[i] = 1'b0;
            end else if (!ce) begin
                md[i] = 1'b0;
            end else if (load) begin
                md[i] = (mc[i] == 1);
                mc[i] = mw[i];
                for (int k = 0; k < mw[i]; k++)
                    mb[i][k] = ml[i] ? p[k] : p[mw[i]-1-k];
            end else begin
                md[i] = (mc[i] == 1);
                if (mc[i] > 0) mc[i] = mc[i] - 1;
                for (int k = 0; k < mw[i] - 1; k++) mb[i][k] = mb[i][k+1];
                mb[i][mw[i]-1] = si;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; load = 1'b1; pi4 = 4'hF; pi8 = 8'hFF; si = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst = 1'b0; load = 1'b0; si = 1'b0;
            end
            step();
            n_checks++;
            if ({o4m, b4m, d4m, c4m} !== 6'b0)
                $display("FAIL reset u4m cyc %0d: got %b want %b", i, {o4m, b4m, d4m, c4m}, 6'b0);
            else n_pass++;
            n_checks++;
            if ({o4l, b4l, d4l, c4l} !== 6'b0)
                $display("FAIL reset u4l cyc %0d: got %b want %b", i, {o4l, b4l, d4l, c4l}, 6'b0);
            else n_pass++;
            n_checks++;
            if ({o8m, b8m, d8m, c8m} !== 7'b0)
                $display("FAIL reset u8m cyc %0d: got %b want %b", i, {o8m, b8m, d8m, c8m}, 7'b0);
            else n_pass++;
        end
    endtask

    task automatic test_msb_first();
        bit         eo[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int         ec[5] = '{4, 3, 2, 1, 0};
        logic [5:0] exp;
        ce = 1'b1; si = 1'b0; load = 1'b1; pi4 = 4'b1011;
        step();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) exp = {eo[k], ec[k] != 0, k == 4, 3'(ec[k])};
            else       exp = 6'b0;
            n_checks++;
            if ({o4m, b4m, d4m, c4m} !== exp)
                $display("FAIL msb_first cyc %0d: got %b want %b", k, {o4m, b4m, d4m, c4m}, exp);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_lsb_stall();
        bit         ce_t[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bit         eo[9]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int         ec[9]   = '{3, 3, 3, 3, 2, 1, 0, 0, 0};
        logic [5:0] exp;
        ce = 1'b1; si = 1'b1; load = 1'b1; pi4 = 4'b1011;
        step();
        load = 1'b0;
        n_checks++;
        if ({o4l, b4l, d4l, c4l} !== 6'b1_1_0_100)
            $display("FAIL lsb_load: got %b want %b", {o4l, b4l, d4l, c4l}, 6'b1_1_0_100);
        else n_pass++;
        for (int k = 0; k < 9; k++) begin
            ce = ce_t[k];
            step();
            exp = {eo[k], ec[k] != 0, k == 6, 3'(ec[k])};
            n_checks++;
            if ({o4l, b4l, d4l, c4l} !== exp)
                $display("FAIL lsb_stall cyc %0d: got %b want %b", k, {o4l, b4l, d4l, c4l}, exp);
            else n_pass++;
        end
        ce = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w = 16'hA53C;
        logic [6:0]  exp;
        int          dones = 0;
        ce = 1'b1; si = 1'b0; load = 1'b1; pi8 = 8'hA5;
        step();
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = {w[15-k], 1'b1, k == 8, 4'(8 - (k % 8))};
            if (d8m) dones++;
            n_checks++;
            if ({o8m, b8m, d8m, c8m} !== exp)
                $display("FAIL b2b bit %0d: got %b want %b", k, {o8m, b8m, d8m, c8m}, exp);
            else n_pass++;
            if (k == 7) begin
                load = 1'b1; pi8 = 8'h3C;
            end
            step();
            load = 1'b0;
        end
        if (d8m) dones++;
        n_checks++;
        if ({b8m, d8m, c8m} !== 6'b0_1_0000)
            $display("FAIL b2b end: got %b want %b", {b8m, d8m, c8m}, 6'b0_1_0000);
        else n_pass++;
        n_checks++;
        if (dones !== 2)
            $display("FAIL b2b done_count: got %0d want 2", dones);
        else n_pass++;
    endtask

    task automatic test_abort_reset();
        ce = 1'b1; si = 1'b0; load = 1'b1; pi8 = 8'hFF;
        step();
        load = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({o8m, b8m, d8m, c8m} !== 7'b1_1_0_0101)
            $display("FAIL abort pre: got %b want %b", {o8m, b8m, d8m, c8m}, 7'b1_1_0_0101);
        else n_pass++;
        load = 1'b1; pi8 = 8'h00;
        step();
        load = 1'b0;
        n_checks++;
        if ({o8m, b8m, d8m, c8m} !== 7'b0_1_0_1000)
            $display("FAIL abort load: got %b want %b", {o8m, b8m, d8m, c8m}, 7'b0_1_0_1000);
        else n_pass++;
        repeat (2) step();
        n_checks++;
        if ({o8m, b8m, d8m, c8m} !== 7'b0_1_0_0110)
            $display("FAIL abort shift: got %b want %b", {o8m, b8m, d8m, c8m}, 7'b0_1_0_0110);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o8m, b8m, d8m, c8m} !== 7'b0)
                $display("FAIL midword_reset cyc %0d: got %b want %b", k, {o8m, b8m, d8m, c8m}, 7'b0);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_idle_pass();
        bit         sp[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0] exp;
        ce = 1'b1; load = 1'b0;
        for (int t = 0; t < 10; t++) begin
            si = (t < 5) ? sp[t] : 1'b0;
            step();
            exp = 6'b0;
            if (t >= 3 && t < 8) exp[5] = sp[t-3];
            n_checks++;
            if ({o4m, b4m, d4m, c4m} !== exp)
                $display("FAIL idle_pass cyc %0d: got %b want %b", t, {o4m, b4m, d4m, c4m}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        rst = 1'b1; ce = 1'b1; load = 1'b0; si = 1'b0;
        model_edge();
        step();
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 63) == 0);
            ce   = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 5) == 0);
            si   = 1'($urandom);
            pi4  = 4'($urandom);
            pi8  = 8'($urandom);
            model_edge();
            step();
            n_checks++;
            if ({o4m, b4m, d4m, c4m} !== {mb[0][0], mc[0] != 0, md[0], 3'(mc[0])})
                $display("FAIL rand u4m cyc %0d: got %b want %b", n, {o4m, b4m, d4m, c4m},
                         {mb[0][0], mc[0] != 0, md[0], 3'(mc[0])});
            else n_pass++;
            n_checks++;
            if ({o4l, b4l, d4l, c4l} !== {mb[1][0], mc[1] != 0, md[1], 3'(mc[1])})
                $display("FAIL rand u4l cyc %0d: got %b want %b", n, {o4l, b4l, d4l, c4l},
                         {mb[1][0], mc[1] != 0, md[1], 3'(mc[1])});
            else n_pass++;
            n_checks++;
            if ({o8m, b8m, d8m, c8m} !== {mb[2][0], mc[2] != 0, md[2], 4'(mc[2])})
                $display("FAIL rand u8m cyc %0d: got %b want %b", n, {o8m, b8m, d8m, c8m},
                         {mb[2][0], mc[2] != 0, md[2], 4'(mc[2])});
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; si = 1'b0; load = 1'b0; pi4 = '0; pi8 = '0;
        test_reset();
        test_msb_first();
        test_lsb_stall();
        test_back_to_back();
        test_abort_reset();
        test_idle_pass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out shift register, the successor to the fixed 2-bit PISO. It loads a WIDTH-bit word and shifts it out one bit per enabled clock. It tracks the remaining bits, so downstream logic gets BUSY/DONE framing and can issue back-to-back loads without gaps. It sits between parallel datapaths and serial links (SPI-style TX, LED/shift-chain drivers) on the single system clock.

## Interface
Parameters:
- WIDTH, 8: word length in bits; legal range 2..64.
- LSB_FIRST, 0: 0 shifts MSB first, with SI entering at bit 0; 1 shifts LSB first, with SI entering at bit WIDTH-1.

Ports:
- Clock and reset: one clock, CLK; reset is synchronous and active-high, RESET.
- CLK, input, 1: rising-edge clock.
- RESET, input, 1: synchronous active-high reset; overrides all other inputs.
- CE, input, 1: clock enable; gates LOAD and shifting.
- SI, input, 1: serial input; shifted into the vacated end of the register.
- PI, input, WIDTH: parallel word, captured on load.
- LOAD, input, 1: load request; acted on only when CE=1.
- O, output, 1: serial output; the register's exit bit.
- BUSY, output, 1: high while a loaded word has unsent bits.
- DONE, output, 1: one-cycle pulse after the final bit of a word is consumed.
- COUNT, output, clog2(WIDTH+1): number of bits of the current word not yet shifted out, counting the bit currently on O.

## Operation
- State: shift register R[WIDTH-1:0], counter COUNT, flag DONE. BUSY = (COUNT != 0). O = R[WIDTH-1] when LSB_FIRST=0, R[0] when LSB_FIRST=1. All outputs are driven from registers only; no combinational input-to-output paths.
- Priority at each rising edge of CLK:
  1. If RESET=1: R=0, COUNT=0, DONE=0.
  2. Else if CE=0: R and COUNT hold; DONE=0.
  3. Else if LOAD=1: R=PI, COUNT=WIDTH, DONE=(COUNT==1).
  4. Else (CE=1, LOAD=0), shift:
     - LSB_FIRST=0: R={R[WIDTH-2:0],SI}.
     - LSB_FIRST=1: R={SI,R[WIDTH-1:1]}.
     - If COUNT>0, COUNT decrements, and DONE=(COUNT==1). If COUNT=0, COUNT stays 0 and DONE=0.
- Idle shifting (COUNT=0, CE=1) keeps running. This preserves plain shift-register behaviour, so SI can be chained through cascaded instances with no framing.
- LOAD while BUSY aborts the current word: the new word is loaded immediately and the remaining old bits are discarded. DONE is not pulsed, except in the COUNT==1 case below.
- Back-to-back: LOAD at the edge where COUNT==1 completes the old word (its last bit was on O during that cycle), so DONE=1 and the new word starts. BUSY stays high continuously.
- DONE is high for exactly one clock cycle. It clears on the next edge regardless of CE.

## Timing
- Reset values: R=0, O=0, COUNT=0, BUSY=0, DONE=0. Reset takes effect at the first rising edge with RESET=1, even mid-word; the in-flight word is lost and DONE is not pulsed.
- Load latency: LOAD&CE sampled at edge k means the first bit of the word is on O in the cycle after edge k, with BUSY=1 and COUNT=WIDTH.
- Bit n (0-based, in shift order) appears on O after the n-th subsequent enabled shift edge. Stalls with CE=0 hold O and COUNT indefinitely.
- The last bit is on O while COUNT=1. The next enabled edge sets COUNT=0 and DONE=1. Word throughput is WIDTH enabled cycles per word with zero gap.
- The SI bit shifted in at edge j reaches O after WIDTH enabled edges, so throughput from SI to O is WIDTH cycles of latency.

## Test plan
- Reset and idle: assert RESET for 2 cycles with CE=1, LOAD=1, PI=all ones. Required: O=0, BUSY=0, COUNT=0, DONE=0 throughout and in the first cycle after release.
- MSB-first word: WIDTH=4, LSB_FIRST=0; LOAD PI=4'b1011, then 4 shift cycles with SI=0. Required: O sequence 1,0,1,1; COUNT 4,3,2,1,0; DONE high only in the cycle where COUNT=0; BUSY low afterwards.
- LSB-first and CE stall: WIDTH=4, LSB_FIRST=1; LOAD PI=4'b1011, then drop CE for 3 cycles after the first shift. Required: O sequence 1,1,0,1, with O=1 and COUNT=3 held during the stall. Then SI=1 fill appears on O after the word.
- Back-to-back: WIDTH=8; LOAD 8'hA5, then LOAD 8'h3C in the cycle where COUNT=1. Required: 16 contiguous bits A5 then 3C, MSB first; BUSY never drops; DONE pulses once at the handover and once after 3C.
- Abort and mid-word reset: LOAD 8'hFF, shift 3 bits, LOAD 8'h00. Required: O becomes 0, COUNT=8, no DONE. After 2 more shifts, pulse RESET. Required: all outputs 0 on the next cycle, no DONE.
- Idle pass-through: COUNT=0, WIDTH=4, drive SI pattern 1,1,0,1,0. Required: the same pattern on O delayed 4 enabled cycles; COUNT stays 0; DONE never asserts.
